// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg
//   Definitions shared by the RAM stream reader and its bench.
//   - state_t   : FSM state encoding (IDLE, READ, PRESENT, FINISH)
//   - HDR_WORDS : word count of a block header, the reader's main use-case
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_PRESENT = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    localparam int HDR_WORDS = 20;

endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if
//   valid/ready word stream from the RAM reader to the hashing datapath.
//   - valid : word on data is valid
//   - ready : downstream accepts the word when valid & ready at posedge
//   - data  : stream word, held stable while valid & !ready
//   - last  : marks the final word of a run
//   Modports: master (reader side), slave (consumer side).
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side initiator for the single-port negedge RAM. A start pulse in IDLE
//   latches a base address and word count; the block then fetches that many
//   consecutive words (address wrapping modulo the RAM size) and presents them
//   one at a time on a valid/ready stream, flagging the final word with last.
//   A one-cycle done pulse follows the last handshake.
// Ports
//   clk          system clock, shared with the RAM
//   reset_n      asynchronous active-low reset
//   start        one-cycle request pulse, honoured only in IDLE
//   base_addr    first word address (latched on start)
//   word_count   number of words to fetch (latched on start)
//   busy         high while a run with data is in progress
//   done         one-cycle completion pulse
//   ram_addr     RAM address (registered; RAM samples it on the falling edge)
//   ram_wEn      RAM write enable, always 0
//   ram_dataIn   RAM write data, always 0
//   ram_dataOut  RAM read data, valid one cycle after ram_addr changes
//   stream       outgoing word stream (master side)
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 12,
    parameter  int MAX_WORDS     = 32,
    localparam int CW            = $clog2(MAX_WORDS + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [CW-1:0]            word_count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_wEn,
    output logic [DATA_WIDTH-1:0]    ram_dataIn,
    input  logic [DATA_WIDTH-1:0]    ram_dataOut,
    ram_stream_reader_if.master      stream
);

    // Current register values
    state_t                     state_r;
    logic [ADDRESS_WIDTH-1:0]   base_r;
    logic [CW-1:0]              count_r;
    logic [CW-1:0]              idx_r;
    logic [ADDRESS_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]      data_r;
    logic                       valid_r;
    logic                       last_r;
    logic                       busy_r;
    logic                       done_r;

    // Next-state values
    state_t                     state_s;
    logic [ADDRESS_WIDTH-1:0]   base_s;
    logic [CW-1:0]              count_s;
    logic [CW-1:0]              idx_s;
    logic [ADDRESS_WIDTH-1:0]   addr_s;
    logic [DATA_WIDTH-1:0]      data_s;
    logic                       valid_s;
    logic                       last_s;
    logic                       busy_s;
    logic                       done_s;

    logic                       handshake_s;
    logic [CW-1:0]              idx_inc_s;

    assign handshake_s = valid_r & stream.ready;
    assign idx_inc_s   = idx_r + CW'(1'b1);

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers; busy/done are registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r  <= {ADDRESS_WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            idx_r   <= {CW{1'b0}};
            addr_r  <= {ADDRESS_WIDTH{1'b0}};
            data_r  <= {DATA_WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            base_r  <= base_s;
            count_r <= count_s;
            idx_r   <= idx_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_s = state_r;
        base_s  = base_r;
        count_s = count_r;
        idx_s   = idx_r;
        addr_s  = addr_r;
        data_s  = data_r;
        valid_s = valid_r;
        last_s  = last_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (word_count != {CW{1'b0}}) begin
                        base_s  = base_addr;
                        count_s = word_count;
                        idx_s   = {CW{1'b0}};
                        addr_s  = base_addr;
                        busy_s  = 1'b1;
                        state_s = S_READ;
                    end else begin
                        // Empty run: complete immediately without touching the stream
                        done_s  = 1'b1;
                        state_s = S_FINISH;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_READ: begin
                // ram_dataOut now reflects addr_r (sampled by the RAM on the falling edge)
                data_s  = ram_dataOut;
                valid_s = 1'b1;
                last_s  = (idx_r == (count_r - CW'(1'b1)));
                busy_s  = 1'b1;
                state_s = S_PRESENT;
            end

            S_PRESENT: begin
                if (handshake_s) begin
                    valid_s = 1'b0;
                    if (last_r) begin
                        done_s  = 1'b1;
                        state_s = S_FINISH;
                    end else begin
                        // Address wraps modulo 2^ADDRESS_WIDTH by truncation
                        idx_s   = idx_inc_s;
                        addr_s  = base_r + ADDRESS_WIDTH'(idx_inc_s);
                        busy_s  = 1'b1;
                        state_s = S_READ;
                    end
                end else begin
                    busy_s  = 1'b1;
                    state_s = S_PRESENT;
                end
            end

            S_FINISH: begin
                last_s  = 1'b0;
                state_s = S_IDLE;
            end

            default: begin
                valid_s = 1'b0;
                last_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign ram_addr     = addr_r;
    assign ram_wEn      = 1'b0;
    assign ram_dataIn   = {DATA_WIDTH{1'b0}};
    assign stream.valid = valid_r;
    assign stream.data  = data_r;
    assign stream.last  = last_r;

endmodule
